// File: rtl/pressure_pkg.sv
// Shared types and default framing constants for the pressure-matrix UART path.
package pressure_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_SEQ,
        ST_PAYLOAD,
        ST_CSUM,
        ST_TAIL
    } state_t;

    // One candidate UART issue for the current cycle.
    typedef struct packed {
        logic       en;
        logic       pop;
        logic [7:0] data;
    } tx_req_t;

    localparam logic [7:0] DEF_SYNC0     = 8'hAA;
    localparam logic [7:0] DEF_SYNC1     = 8'h55;
    localparam logic [7:0] DEF_TAIL      = 8'h0D;
    localparam int         DEF_FRAME_LEN = 256;

endpackage

// File: rtl/crc8_update.sv
// One-byte CRC-8 step, polynomial 0x07, MSB first, purely combinational.
module crc8_update (
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    always_comb begin
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        crc_next = c;
    end

endmodule

// File: rtl/uart_frame_packer.sv
// Drains one FWFT FIFO frame into the UART as SYNC0 SYNC1 SEQ payload CSUM TAIL.
// Define PACKER_CRC8_EN to send CRC-8 instead of the additive checksum.
module uart_frame_packer
    import pressure_pkg::*;
#(
    parameter int          FRAME_LEN = DEF_FRAME_LEN,
    parameter logic [7:0]  SYNC0     = DEF_SYNC0,
    parameter logic [7:0]  SYNC1     = DEF_SYNC1,
    parameter logic [7:0]  TAIL      = DEF_TAIL,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic [7:0] seq_num,
    output logic       frame_sent,
    output logic       frame_underrun
);

    localparam logic [15:0] LAST = 16'(FRAME_LEN - 1);

    state_t      state, state_nxt;
    tx_req_t     req;
    logic [15:0] byte_cnt;
    logic [15:0] tmo_cnt;
    logic        pad_r;
    logic        uflag;
    logic [7:0]  csum;
    logic [7:0]  csum_nxt;
    logic        ready;
    logic        pad_now;
    logic        last_byte;

    // uart_tx_en high last cycle blocks this one so busy has time to rise.
    assign ready     = !uart_tx_busy && !uart_tx_en;
    assign pad_now   = pad_r || (tmo_cnt == TIMEOUT);
    assign last_byte = (byte_cnt == LAST);

`ifdef PACKER_CRC8_EN
    crc8_update u_crc (
        .crc      (csum),
        .data     (req.data),
        .crc_next (csum_nxt)
    );
`else
    assign csum_nxt = csum + req.data;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (!fifo_empty) state_nxt = ST_SYNC0;
            ST_SYNC0:   if (ready) state_nxt = ST_SYNC1;
            ST_SYNC1:   if (ready) state_nxt = ST_SEQ;
            ST_SEQ:     if (ready) state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: if (ready && (pad_now || !fifo_empty) && last_byte) state_nxt = ST_CSUM;
            ST_CSUM:    if (ready) state_nxt = ST_TAIL;
            ST_TAIL:    if (ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req = '0;
        case (state)
            ST_SYNC0: begin req.en = ready; req.data = SYNC0;   end
            ST_SYNC1: begin req.en = ready; req.data = SYNC1;   end
            ST_SEQ:   begin req.en = ready; req.data = seq_num; end
            ST_PAYLOAD: begin
                // Padding wins over a late byte: that byte belongs to the next frame.
                if (ready && pad_now) begin
                    req.en = 1'b1;
                end else if (ready && !fifo_empty) begin
                    req.en   = 1'b1;
                    req.pop  = 1'b1;
                    req.data = fifo_rd_data;
                end
            end
            ST_CSUM:  begin req.en = ready; req.data = csum;    end
            ST_TAIL:  begin req.en = ready; req.data = TAIL;    end
            default:  req = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_tx_en     <= 1'b0;
            uart_tx_data   <= 8'h00;
            fifo_rd_en     <= 1'b0;
            frame_sent     <= 1'b0;
            frame_underrun <= 1'b0;
            seq_num        <= 8'h00;
            csum           <= 8'h00;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            pad_r          <= 1'b0;
            uflag          <= 1'b0;
        end else begin
            uart_tx_en     <= req.en;
            fifo_rd_en     <= req.pop;
            frame_sent     <= req.en && (state == ST_TAIL);
            frame_underrun <= req.en && (state == ST_TAIL) && uflag;
            if (req.en) uart_tx_data <= req.data;

            if (state == ST_IDLE && !fifo_empty)
                csum <= 8'h00;
            else if (req.en && (state == ST_SEQ || state == ST_PAYLOAD))
                csum <= csum_nxt;

            if (req.en && state == ST_TAIL) begin
                seq_num <= seq_num + 8'd1;
                uflag   <= 1'b0;
            end

            if (state == ST_PAYLOAD) begin
                if (req.en) byte_cnt <= last_byte ? 16'd0 : byte_cnt + 16'd1;
                if (pad_now) begin
                    pad_r <= 1'b1;
                    uflag <= 1'b1;
                end else if (!fifo_empty) begin
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                if (req.en && last_byte) begin
                    pad_r   <= 1'b0;
                    tmo_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with FRAME_LEN=4, TIMEOUT=16.
module tb_uart_frame_packer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        uart_tx_busy;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic [7:0]  seq_num;
    logic        frame_sent;
    logic        frame_underrun;

    always #10 sys_clk = ~sys_clk;

    uart_frame_packer #(.FRAME_LEN(4), .TIMEOUT(16'd16)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_en     (fifo_rd_en),
        .uart_tx_busy   (uart_tx_busy),
        .uart_tx_en     (uart_tx_en),
        .uart_tx_data   (uart_tx_data),
        .seq_num        (seq_num),
        .frame_sent     (frame_sent),
        .frame_underrun (frame_underrun)
    );

    // FWFT FIFO model; flushed together with the system reset.
    logic [7:0]  mem [0:1023];
    logic [15:0] wr_ptr = 16'd0;
    logic [15:0] rd_ptr;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_rd_data = mem[rd_ptr[9:0]];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                    rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 16'd1;
    end

    // Transmitter model: busy for busy_len cycles after each send strobe.
    int busy_len = 0;
    int bcnt;
    assign uart_tx_busy = (bcnt != 0);
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                       bcnt <= 0;
        else if (uart_tx_en && busy_len != 0) bcnt <= busy_len;
        else if (bcnt != 0)                   bcnt <= bcnt - 1;
    end

    logic [7:0] cap [0:4095];
    int ncap = 0, fs_cnt = 0, ur_cnt = 0, ur_alone = 0, rd_cnt = 0, viol = 0;
    always @(negedge sys_clk) begin
        if (uart_tx_en) begin
            cap[ncap] <= uart_tx_data;
            ncap      <= ncap + 1;
        end
        if (fifo_rd_en)                    rd_cnt   <= rd_cnt + 1;
        if (frame_sent)                    fs_cnt   <= fs_cnt + 1;
        if (frame_underrun)                ur_cnt   <= ur_cnt + 1;
        if (frame_underrun && !frame_sent) ur_alone <= ur_alone + 1;
        if ((uart_tx_en && uart_tx_busy) || (fifo_rd_en && fifo_empty)) viol <= viol + 1;
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] ex [0:8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[9:0]] = b;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    function automatic logic [7:0] model_csum(input logic [7:0] s, p0, p1, p2, p3);
        logic [7:0] c;
        logic [7:0] b [0:4];
        b[0] = s; b[1] = p0; b[2] = p1; b[3] = p2; b[4] = p3;
        c = 8'h00;
`ifdef PACKER_CRC8_EN
        for (int k = 0; k < 5; k++)
            for (int j = 7; j >= 0; j--)
                c = (c[7] ^ b[k][j]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
`else
        for (int k = 0; k < 5; k++) c = c + b[k];
`endif
        return c;
    endfunction

    task automatic set_ex(input logic [7:0] s, p0, p1, p2, p3);
        ex[0] = 8'hAA; ex[1] = 8'h55; ex[2] = s;
        ex[3] = p0; ex[4] = p1; ex[5] = p2; ex[6] = p3;
        ex[7] = model_csum(s, p0, p1, p2, p3);
        ex[8] = 8'h0D;
    endtask

    task automatic chk_frame(input string tag, input int base);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s[%0d]", tag, i), {24'd0, cap[base + i]}, {24'd0, ex[i]});
    endtask

    task automatic wait_sent(input int target, input string tag);
        for (int i = 0; i < 3000 && fs_cnt < target; i++) @(posedge sys_clk);
        chk({tag, "_sent"}, fs_cnt, target);
    endtask

    task automatic wait_cap(input int target, input string tag);
        for (int i = 0; i < 3000 && ncap < target; i++) @(posedge sys_clk);
        chk({tag, "_cap"}, 32'(ncap >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, rd0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_rd_en",     fifo_rd_en,     0);
        chk("rst_tx_en",     uart_tx_en,     0);
        chk("rst_tx_data",   uart_tx_data,   0);
        chk("rst_seq",       seq_num,        0);
        chk("rst_sent",      frame_sent,     0);
        chk("rst_underrun",  frame_underrun, 0);
        @(negedge sys_clk) sys_rst_n = 1'b1;

        // Frame seq 0: 01 02 03 04 -> csum 0A, SYNC0 strobe two cycles after data lands
        @(negedge sys_clk);
        base = ncap; rd0 = rd_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        @(posedge sys_clk); #1;
        chk("lat_idle_en", uart_tx_en, 0);
        @(posedge sys_clk); #1;
        chk("lat_sync0_en",   uart_tx_en,   1);
        chk("lat_sync0_data", uart_tx_data, 8'hAA);
        wait_sent(1, "f0");
        set_ex(8'h00, 8'h01, 8'h02, 8'h03, 8'h04);
        chk_frame("f0", base);
        chk("f0_seq",  seq_num, 1);
        chk("f0_pops", rd_cnt - rd0, 4);
        chk("f0_ur",   ur_cnt, 0);

        // Frame seq 1 with a slow transmitter: csum 0B, no strobe during busy
        @(negedge sys_clk);
        busy_len = 20; base = ncap; rd0 = rd_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_sent(2, "busy");
        set_ex(8'h01, 8'h01, 8'h02, 8'h03, 8'h04);
        chk_frame("busy", base);
        chk("busy_pops", rd_cnt - rd0, 4);
        chk("busy_viol", viol, 0);
        busy_len = 0;

        // Frame seq 2 underruns after 01 02; bytes pushed during padding wait for seq 3
        @(negedge sys_clk);
        base = ncap; rd0 = rd_cnt;
        push(8'h01); push(8'h02);
        wait_cap(base + 6, "ur_pad");
        @(negedge sys_clk);
        push(8'h03); push(8'h04); push(8'h05); push(8'h06);
        wait_sent(3, "ur");
        set_ex(8'h02, 8'h01, 8'h02, 8'h00, 8'h00);
        chk_frame("ur", base);
        chk("ur_pulse", ur_cnt, 1);
        chk("ur_alone", ur_alone, 0);
        wait_sent(4, "post_ur");
        set_ex(8'h03, 8'h03, 8'h04, 8'h05, 8'h06);
        chk_frame("post_ur", base + 9);
        chk("post_ur_pops", rd_cnt - rd0, 6);
        chk("post_ur_nour", ur_cnt, 1);

        // Reset mid-payload, then a fresh frame restarts at seq 0
        @(negedge sys_clk);
        busy_len = 20; base = ncap;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_cap(base + 4, "midrst");
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("mrst_rd_en",    fifo_rd_en,     0);
        chk("mrst_tx_en",    uart_tx_en,     0);
        chk("mrst_tx_data",  uart_tx_data,   0);
        chk("mrst_seq",      seq_num,        0);
        chk("mrst_sent",     frame_sent,     0);
        chk("mrst_underrun", frame_underrun, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1; busy_len = 0;
        @(negedge sys_clk);
        base = ncap;
        push(8'h09); push(8'h08); push(8'h07); push(8'h06);
        wait_sent(5, "rst");
        set_ex(8'h00, 8'h09, 8'h08, 8'h07, 8'h06);
        chk_frame("rst", base);

        // 256 more frames: SEQ runs 01..FF then wraps to 00
        for (int f = 1; f <= 256; f++) begin
            logic [7:0] p [0:3];
            @(negedge sys_clk);
            base = ncap;
            for (int i = 0; i < 4; i++) begin
                p[i] = 8'(f * 5 + i * 17);
                push(p[i]);
            end
            wait_sent(5 + f, "wrap");
            set_ex(8'(f), p[0], p[1], p[2], p[3]);
            chk_frame($sformatf("wrap%0d", f), base);
        end
        chk("wrap_seq", seq_num, 1);
        chk("final_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_packer.md
# uart_frame_packer

Packetizing stage between the pressure-matrix data FIFO (First-Word-Fall-Through read side) and the UART transmitter. It drains one scan frame of FRAME_LEN bytes from the FIFO and sends it to the UART byte-by-byte inside a fixed envelope: two sync bytes, a sequence number, the payload, a checksum and a tail byte. The PC receiver uses this envelope to detect frame boundaries and lost or corrupted frames.

## Interface
Parameters:
- FRAME_LEN, 256: payload bytes per frame (16x16 sensor cells); legal range 1..65535.
- SYNC0, 8'hAA: first header byte.
- SYNC1, 8'h55: second header byte.
- TAIL, 8'h0D: trailer byte.
- TIMEOUT, 16'd50000: sys_clk cycles of FIFO-empty during payload before underrun padding starts.

Ports:
- sys_clk  in  1  system clock (50 MHz); the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  8  FWFT head-of-FIFO byte; valid while fifo_empty=0.
- fifo_rd_en  out  1  one-cycle pop strobe, registered.
- uart_tx_busy  in  1  transmitter busy.
- uart_tx_en  out  1  one-cycle send strobe, registered.
- uart_tx_data  out  8  byte to send, valid with uart_tx_en, held afterwards.
- seq_num  out  8  sequence number of the current or next frame.
- frame_sent  out  1  one-cycle pulse after TAIL is issued.
- frame_underrun  out  1  one-cycle pulse, coincident with frame_sent, if any payload byte was padded.

## Operation
- States: IDLE, SYNC0, SYNC1, SEQ, PAYLOAD, CSUM, TAIL.
- IDLE → SYNC0 when fifo_empty=0. The block never starts a frame on an empty FIFO.
- Issue condition ("ready"): uart_tx_busy=0 and uart_tx_en was 0 in the previous cycle. This guard cycle lets busy rise before the next issue.
- In each send state, when ready: register uart_tx_en=1 and uart_tx_data=<byte>, then advance. Order: SYNC0 → SYNC1 → SEQ (seq_num) → PAYLOAD → CSUM → TAIL → IDLE.
- PAYLOAD, ready and fifo_empty=0: send fifo_rd_data, pulse fifo_rd_en in the same cycle as uart_tx_en, increment the 16-bit byte counter, and clear the timeout counter.
- PAYLOAD, fifo_empty=1: increment the timeout counter. Once it reaches TIMEOUT, the block enters padding mode for the rest of this frame:
  - Each ready slot sends 8'h00 with no pop.
  - The underrun flag is set.
  - A byte arriving later stays in the FIFO and belongs to the next frame.
- PAYLOAD → CSUM after FRAME_LEN bytes have been issued.
- Checksum: 8-bit sum, modulo 256, of the SEQ byte and every payload byte as issued (padding 0x00 included). It is cleared on entry to SYNC0. SYNC and TAIL bytes are excluded.
- At TAIL issue:
  - frame_sent pulses.
  - frame_underrun pulses if the flag is set; the flag then clears.
  - seq_num increments, wrapping 255 → 0.
- Reset at any point, including mid-frame: state IDLE and all counters 0. The partial frame is abandoned; the PC resynchronizes on SYNC0/SYNC1.

## Timing
- Reset values: fifo_rd_en=0, uart_tx_en=0, uart_tx_data=8'h00, seq_num=0, frame_sent=0, frame_underrun=0.
- Latency: with uart_tx_busy=0, SYNC0's uart_tx_en is asserted 2 cycles after fifo_empty falls (IDLE→SYNC0 takes 1 cycle, the registered issue takes 1).
- Issue rate is at most one byte per 2 cycles. Successive issues otherwise track the fall of uart_tx_busy.
- A frame is exactly FRAME_LEN+5 uart_tx_en pulses (261 by default).
- fifo_rd_en is never asserted while fifo_empty=1 and is never asserted outside PAYLOAD.
- If fifo_empty and busy fall in the same cycle, the first ready cycle is that cycle.

## Configuration
- PACKER_CRC8_EN defined: the CSUM byte is CRC-8 over the same bytes, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB first, no final XOR.
- PACKER_CRC8_EN undefined: the CSUM byte is the modulo-256 additive sum.
- Framing and timing are identical in both builds.

## Structure
- Shared package pressure_pkg holds:
  - the state enum;
  - default constants SYNC0/SYNC1/TAIL;
  - the default FRAME_LEN of 256.
- Sub-module crc8_update: combinational next-CRC from current CRC and data byte. It is instantiated only under PACKER_CRC8_EN.

## Test plan
- FRAME_LEN=4, FIFO preloaded 01 02 03 04, busy always 0 → UART sees AA 55 00 01 02 03 04 0A 0D, frame_sent once, seq_num=1, 4 fifo_rd_en pulses.
- Same load with busy held high 20 cycles after each en → identical byte sequence, no en while busy=1, no lost bytes.
- 256 frames back-to-back → seq_num wraps to 00 on frame 257's SEQ byte; every checksum matches the reference model.
- FRAME_LEN=4, only 01 02 supplied, TIMEOUT=16 → bytes AA 55 00 01 02 00 00 03 0D; frame_underrun and frame_sent pulse together.
- Assert sys_rst_n=0 mid-payload → outputs go to reset values immediately; after release, the next frame begins with AA 55 00.
- PACKER_CRC8_EN, FRAME_LEN=1, payload 00, SEQ 00 → CSUM byte 00; payload FF → CSUM byte F3.
